// File: rtl/rng_collector.sv
`default_nettype none
// ============================================================================
// Module      : rng_collector
// Description : Requester/consumer for a TRNG unit. Issues one-cycle sample
//               requests, packs four returned bytes (first byte in [31:24])
//               into a 32-bit word and buffers words in a first-word-fall-
//               through FIFO that a host drains with a valid/ready handshake.
//               A request left unanswered for TIMEOUT cycles raises a sticky
//               error and discards the partially assembled word.
// Ports       : CLK, RST (async, active high)     - clock / reset
//               ENABLE, CLEAR                     - run level / sync flush
//               RNG_EN, RNG_DATA, RNG_VALID       - TRNG request/response
//               WORD_OUT, WORD_VALID, WORD_READY  - host FIFO read port
//               COUNT, TIMEOUT_ERR                - FIFO fill level / error
// Revision    : 1.0 - initial release
// ============================================================================
module rng_collector #(
    parameter int FIFO_DEPTH = 8,      // power of two, >= 2
    parameter int TIMEOUT    = 65535   // >= 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          ENABLE,
    input  logic                          CLEAR,
    output logic                          RNG_EN,
    input  logic [15:0]                   RNG_DATA,
    input  logic                          RNG_VALID,
    output logic [31:0]                   WORD_OUT,
    output logic                          WORD_VALID,
    input  logic                          WORD_READY,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          TIMEOUT_ERR
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_TW = $clog2(TIMEOUT);

    localparam logic [c_CW-1:0] c_FULL       = c_CW'(FIFO_DEPTH);
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_rng_en;
    logic [c_TW-1:0]   r_timer;
    logic [31:0]       r_asm;
    logic [1:0]        r_byte_cnt;
    logic              r_err;

    logic [31:0]       r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_CW-1:0]   r_count;

    logic              w_capture;
    logic              w_timeout;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_word;
    logic              w_unused;

    // Upper half of the sample bus carries nothing of interest.
    assign w_unused = ^RNG_DATA[15:8];

    // ------------------------------------------------------------------
    // Next-state logic. CLEAR overrides everything, which also drops any
    // RNG_VALID arriving in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        if (CLEAR) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Fullness is checked before every request, so the word
                    // being assembled always has a free slot when it lands.
                    if (ENABLE && (r_count < c_FULL)) begin
                        w_state_next = S_REQ;
                    end
                end
                S_REQ: begin
                    w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (RNG_VALID) begin
                        w_capture    = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (r_timer == c_TIMER_LAST) begin
                        w_timeout    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign w_word     = {r_asm[23:0], RNG_DATA[7:0]};
    assign w_push     = w_capture && (r_byte_cnt == 2'd3);
    assign WORD_VALID = (r_count != '0);
    assign w_pop      = WORD_VALID && WORD_READY;

    // ------------------------------------------------------------------
    // Control state, assembly register and error flag.
    // RNG_EN comes straight from a flop loaded with "next state is REQ",
    // so the request pulse is glitch-free and exactly one cycle wide.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_rng_en   <= 1'b0;
            r_timer    <= '0;
            r_asm      <= '0;
            r_byte_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rng_en <= (w_state_next == S_REQ);
            if (CLEAR) begin
                r_timer    <= '0;
                r_asm      <= '0;
                r_byte_cnt <= '0;
                r_err      <= 1'b0;
            end else begin
                if (r_state == S_REQ) begin
                    r_timer <= '0;
                end else if (r_state == S_WAIT) begin
                    r_timer <= r_timer + 1'b1;
                end
                if (w_capture) begin
                    r_asm      <= w_word;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end else if (w_timeout) begin
                    r_asm      <= '0;
                    r_byte_cnt <= '0;
                    r_err      <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and fill level. Pointers wrap naturally because the
    // depth is a power of two.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (CLEAR) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only visible through a non-empty FIFO.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    assign WORD_OUT    = WORD_VALID ? r_mem[r_rd_ptr] : 32'h0;
    assign RNG_EN      = r_rng_en;
    assign COUNT       = r_count;
    assign TIMEOUT_ERR = r_err;

endmodule
`default_nettype wire

// File: doc/rng_collector.md
Name: rng_collector

Overview:
- Consumer and requester on the far side of the TRNG unit's RNG_EN / DATA_OUT / DATA_EN interface.
- Issues one-cycle sample requests and captures each returned byte.
- Packs four bytes into a 32-bit word and buffers words in a small first-word-fall-through FIFO, which a host drains with a valid/ready handshake.
- Flags a sticky error if the TRNG unit fails to answer within a timeout.

Parameters:
FIFO_DEPTH, 8, number of 32-bit words buffered; power of two, at least 2
TIMEOUT, 65535, maximum cycles to wait for RNG_VALID after a request; at least 2

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous, active-high reset
ENABLE  input  1  level; while high, the block keeps requesting samples
CLEAR  input  1  synchronous flush (one-cycle pulse or level)
RNG_EN  output  1  one-cycle request pulse to the TRNG unit
RNG_DATA  input  16  sample from the TRNG unit; only [7:0] is used, [15:8] is ignored
RNG_VALID  input  1  one-cycle strobe; RNG_DATA is valid in this cycle
WORD_OUT  output  32  head-of-FIFO word
WORD_VALID  output  1  high when the FIFO is not empty
WORD_READY  input  1  host accepts WORD_OUT when WORD_VALID and WORD_READY are both high
COUNT  output  $clog2(FIFO_DEPTH)+1  number of words in the FIFO
TIMEOUT_ERR  output  1  sticky; set when a request times out

Behaviour:
- Reset (RST high, asynchronous): FSM goes to IDLE. FIFO is empty, assembly register is 0, byte counter is 0, timer is 0. All outputs are 0: RNG_EN, WORD_VALID, WORD_OUT, COUNT and TIMEOUT_ERR.
- FSM states are IDLE, REQ and WAIT.
  - IDLE: moves to REQ when ENABLE=1, CLEAR=0 and COUNT<FIFO_DEPTH. Otherwise stays in IDLE.
  - REQ: RNG_EN=1 for exactly this one cycle, which is registered and glitch-free. Next state is always WAIT, and the timer is cleared.
  - WAIT: timer increments each cycle. If RNG_VALID=1, the block captures RNG_DATA[7:0] and returns to IDLE. If the timer reaches TIMEOUT-1 with no RNG_VALID, TIMEOUT_ERR is set, the partial word and byte counter are discarded, and the FSM returns to IDLE.
- Back-to-back requests: the minimum spacing is 3 cycles (REQ, WAIT with valid, IDLE).
- Byte capture:
  - The assembly register shifts as asm <= {asm[23:0], byte}, so the first byte of a word ends up in [31:24].
  - The byte counter counts 0 to 3.
  - On the 4th byte, the word {asm[23:0], byte} is pushed into the FIFO and the byte counter wraps to 0.
- Latency: the pushed word is visible on WORD_OUT/WORD_VALID/COUNT the cycle after the 4th RNG_VALID.
- RNG_VALID outside WAIT is ignored; no byte is captured and no state changes.
- FIFO:
  - Uses a circular buffer with pointers that wrap modulo FIFO_DEPTH.
  - WORD_OUT always shows the head entry, and shows 0 when empty.
  - A pop happens when WORD_VALID and WORD_READY are both high. WORD_READY while empty has no effect.
  - Simultaneous push and pop: COUNT is unchanged, and both pointers advance.
- FIFO full:
  - No new request starts while COUNT==FIFO_DEPTH.
  - An in-flight word always has room, because the full check is made before every request and only pops can occur between checks. A push into a full FIFO is therefore impossible; verification asserts this.
- ENABLE falling mid-word:
  - A request in progress (REQ or WAIT) completes normally.
  - The partial word and byte counter are retained, and assembly resumes when ENABLE returns.
- CLEAR (synchronous, highest priority after reset):
  - Empties the FIFO, zeroes the assembly register, byte counter and timer, and clears TIMEOUT_ERR.
  - The FSM goes to IDLE and no RNG_EN is issued in that cycle.
  - An RNG_VALID in the same cycle as CLEAR is dropped.
- TIMEOUT_ERR is cleared only by CLEAR or RST. Operation continues after an error.

Test Plan:
- Basic packing: after reset, ENABLE=1 and a responder answers each RNG_EN pulse 2 cycles later with bytes 0x11, 0x22, 0x33, 0x44, all with RNG_DATA[15:8]=0xFF. Required: WORD_OUT=0x11223344, WORD_VALID=1 and COUNT=1 one cycle after the 4th RNG_VALID; exactly four RNG_EN pulses, each one cycle wide.
- Full backpressure: WORD_READY=0 and an always-answering responder, with FIFO_DEPTH=8. Required: COUNT stops at 8, RNG_EN stays low afterwards, and no data is lost. After eight host pops, the words come out in push order and requesting resumes once COUNT<8.
- Simultaneous push/pop: COUNT=3, the 4th byte arrives in the same cycle that WORD_READY=1 pops the head. Required: COUNT stays 3, the head advances to the next word, and the new word is at the tail.
- Timeout: set TIMEOUT=16 and have the responder never answer after 2 bytes have been captured. Required: TIMEOUT_ERR=1 at the 16th WAIT cycle and the FSM returns to IDLE. The next 4 answered bytes 0xA0..0xA3 form word 0xA0A1A2A3, showing the partial word was discarded.
- Stray/CLEAR: RNG_VALID is pulsed while the FSM is in IDLE, which must leave no capture. CLEAR is then asserted with COUNT=5, TIMEOUT_ERR=1 and 2 bytes pending. Required: the next cycle has COUNT=0, WORD_VALID=0 and TIMEOUT_ERR=0, and the next word is assembled from fresh bytes only.
- Async reset mid-WAIT: RST is asserted between clock edges. Required: all outputs are 0 immediately, without waiting for a clock edge, and after release the first request is RNG_EN on the 2nd cycle with ENABLE=1.
